// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the core/host memory arbiter.
//   - arb_state_e : registered arbiter state encoding (IDLE/HOST/CORE/LOCK)
//   - MC_*        : default widths used as parameter defaults
//   - idx_w()     : index width for a requester count (never below 1)
package mc_pkg;

    localparam int MC_NUM_CORES = 4;
    localparam int MC_ADDR_W    = 12;
    localparam int MC_DATA_W    = 16;
    localparam int MC_CNT_W     = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,   // no grant last cycle
        ARB_HOST = 2'd1,   // host granted last cycle
        ARB_CORE = 2'd2,   // core granted last cycle, unlocked
        ARB_LOCK = 2'd3    // core granted last cycle with core_lock set
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/core_mem_arbiter_rr_pick.sv
// rr_pick: round-robin one-hot selector.
//   req [N]     : request vector
//   ptr [PTR_W] : index with highest priority this cycle (must be < N)
//   gnt [N]     : one-hot winner, zero when no request
// Search starts at ptr and wraps past N-1 back to 0.
module rr_pick
    import mc_pkg::*;
#(
    parameter int N     = MC_NUM_CORES,
    parameter int PTR_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            // one extra bit so ptr+k cannot overflow before the wrap
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N))
                sum = sum - (PTR_W+1)'(N);
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: single-port memory arbiter between a host loader and
// NUM_CORES cores.
//   clk, rst_n                 : clock, async active-low reset
//   host_req/we/addr/wdata     : host access request
//   host_gnt                   : host accepted this cycle
//   core_req/we/lock           : per-core request, write enable, lock
//   core_addr/core_wdata       : per-core fields, core 0 at the LSBs
//   core_gnt                   : per-core grant (combinational)
//   core_rvalid/core_rdata     : read return one cycle after a core read
//   mem_en/we/addr/wdata       : memory command (muxed winner fields)
//   mem_rdata                  : synchronous-read data
//   arb_state                  : registered state (mc_pkg::arb_state_e)
//   conflict_cnt               : only with ARB_CONFLICT_CNT_EN defined;
//                                saturating count of cycles with >=2
//                                active requesters
// Priority: locked core (while in LOCK), host, then round-robin cores.
module core_mem_arbiter
    import mc_pkg::*;
#(
    parameter int NUM_CORES = MC_NUM_CORES,
    parameter int ADDR_W    = MC_ADDR_W,
    parameter int DATA_W    = MC_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        host_req,
    input  logic                        host_we,
    input  logic [ADDR_W-1:0]           host_addr,
    input  logic [DATA_W-1:0]           host_wdata,
    output logic                        host_gnt,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES-1:0]        core_lock,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [1:0]                  arb_state
`ifdef ARB_CONFLICT_CNT_EN
    ,
    output logic [MC_CNT_W-1:0]         conflict_cnt
`endif
);

    localparam int IDX_W = idx_w(NUM_CORES);

    arb_state_e                         state;
    logic [IDX_W-1:0]                   rr_ptr;
    logic [IDX_W-1:0]                   lock_id;   // core granted last cycle
    logic [IDX_W-1:0]                   win_idx;
    logic [NUM_CORES-1:0]               rr_gnt;
    logic [NUM_CORES-1:0]               gnt_c;
    logic [NUM_CORES-1:0]               rd_pend;
    logic                               lock_hit;
    logic                               host_win;
    logic                               core_win;
    logic [NUM_CORES-1:0][ADDR_W-1:0]   addr_v;
    logic [NUM_CORES-1:0][DATA_W-1:0]   wdata_v;

    assign addr_v  = core_addr;
    assign wdata_v = core_wdata;

    rr_pick #(
        .N     (NUM_CORES),
        .PTR_W (IDX_W)
    ) u_rr_pick (
        .req (core_req),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    // Grant resolution. Gated by rst_n so grants drop the moment reset
    // asserts, without waiting for a clock.
    always_comb begin
        lock_hit = (state == ARB_LOCK) && core_req[lock_id];
        host_win = 1'b0;
        gnt_c    = '0;
        if (!rst_n) begin
            gnt_c = '0;
        end else if (lock_hit) begin
            gnt_c[lock_id] = 1'b1;
        end else if (host_req) begin
            host_win = 1'b1;
        end else begin
            // lock silently released here if the owner stopped requesting
            gnt_c = rr_gnt;
        end
        core_win = |gnt_c;
        win_idx  = '0;
        for (int k = 0; k < NUM_CORES; k++)
            if (gnt_c[k]) win_idx = IDX_W'(k);
    end

    // Memory command mux; all-zero when nobody wins.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_win) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (core_win) begin
            mem_en    = 1'b1;
            mem_we    = core_we[win_idx];
            mem_addr  = addr_v[win_idx];
            mem_wdata = wdata_v[win_idx];
        end
    end

    assign host_gnt = host_win;
    assign core_gnt = gnt_c;

    // State, round-robin pointer, lock owner and read-return tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
            rd_pend <= '0;
        end else begin
            rd_pend <= gnt_c & ~core_we;
            if (host_win) begin
                state <= ARB_HOST;
            end else if (core_win) begin
                state   <= core_lock[win_idx] ? ARB_LOCK : ARB_CORE;
                lock_id <= win_idx;
                rr_ptr  <= (win_idx == IDX_W'(NUM_CORES-1)) ? '0
                                                             : win_idx + 1'b1;
            end else begin
                state <= ARB_IDLE;
            end
        end
    end

    assign arb_state   = state;
    assign core_rvalid = rd_pend;
    // Read data is broadcast only while a core read is returning.
    assign core_rdata  = (|rd_pend) ? mem_rdata : '0;

`ifdef ARB_CONFLICT_CNT_EN
    logic [$clog2(NUM_CORES+2)-1:0] n_act;

    always_comb begin
        n_act = '0;
        if (host_req) n_act = n_act + 1'b1;
        for (int k = 0; k < NUM_CORES; k++)
            if (core_req[k]) n_act = n_act + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (n_act >= 2 && conflict_cnt != {MC_CNT_W{1'b1}})
            conflict_cnt <= conflict_cnt + 1'b1;
    end
`endif

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, the number of core requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 12, the memory address width.
REQ-003 SHALL have parameter DATA_W, default 16, the memory data width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports host_req/host_we  in  1 each  host loader access request and write enable.
REQ-007 SHALL have ports host_addr  in  ADDR_W  and host_wdata  in  DATA_W  for the host address and write data.
REQ-008 SHALL have port host_gnt  out  1  host access accepted this cycle.
REQ-009 SHALL have ports core_req/core_we/core_lock  in  NUM_CORES each  per-core request, write enable and lock.
REQ-010 SHALL have ports core_addr  in  NUM_CORES*ADDR_W  and core_wdata  in  NUM_CORES*DATA_W, packed with core 0 at the LSBs.
REQ-011 SHALL have ports core_gnt/core_rvalid  out  NUM_CORES each  per-core grant and read-data valid.
REQ-012 SHALL have port core_rdata  out  DATA_W  read data broadcast to all cores.
REQ-013 SHALL have ports mem_en/mem_we  out  1 each  memory enable and write.
REQ-014 SHALL have ports mem_addr  out  ADDR_W  and mem_wdata  out  DATA_W  for the memory address and write data.
REQ-015 SHALL have port mem_rdata  in  DATA_W  synchronous-read data, valid one cycle after a mem_en read.
REQ-016 SHALL have port arb_state  out  2  registered FSM state.

Function
REQ-017 SHALL grant at most one requester per cycle; grants are combinational in the request cycle; mem_* mux the winner's fields.
REQ-018 SHALL resolve priority as: locked core, then host, then cores in round-robin order from rr_ptr.
REQ-019 SHALL set rr_ptr to (winner+1) mod NUM_CORES after a core grant, wrapping from NUM_CORES-1 to 0; host grants and idle cycles SHALL leave rr_ptr unchanged.
REQ-020 SHALL hold mem_en=0, all grants 0 and mem_addr/mem_wdata/mem_we at 0 when no request is pending.
REQ-021 SHALL assert core_rvalid[i] exactly one cycle after a granted core-i read, with core_rdata=mem_rdata; host reads return on mem_rdata with no rvalid; writes SHALL produce no rvalid.
REQ-022 SHALL require requesters to hold req and fields stable until gnt; deasserting req without gnt SHALL drop the request silently.
REQ-023 SHALL implement FSM states IDLE=0 (no grant last cycle), HOST=1 (host granted), CORE=2 (core granted, unlocked) and LOCK=3 (core granted with core_lock=1), with the next state given by the current cycle's grant.
REQ-024 SHALL, in LOCK, reserve the locked core: it wins if requesting; if the locked core does not request, the lock SHALL release and normal arbitration SHALL apply that same cycle.
REQ-025 SHALL ignore core_lock on non-granted cores.
REQ-026 SHALL guarantee that, with the host idle and no lock held, any requesting core is granted within NUM_CORES cycles.

Reset
REQ-027 SHALL, while rst_n=0, immediately set arb_state=IDLE, rr_ptr=0, core_rvalid=0, core_rdata=0 and all grants and mem_en=0, independent of clk.
REQ-028 SHALL drop any read in flight when reset asserts mid-operation, issuing no rvalid after reset release.

Configuration
REQ-029 SHALL, with ARB_CONFLICT_CNT_EN defined, provide output conflict_cnt (16 bits) that counts cycles with two or more active requesters, saturates at 0xFFFF and resets to 0.
REQ-030 SHALL, without ARB_CONFLICT_CNT_EN, omit the conflict_cnt port and its logic entirely.

Structure
REQ-031 SHALL take the arb_state encodings (IDLE/HOST/CORE/LOCK) and default widths from shared package mc_pkg.
REQ-032 SHALL place round-robin winner selection (req vector and rr_ptr in, one-hot out) in sub-module rr_pick.

Verification
REQ-033 SHALL verify: cores 0-3 requesting continuously with the host idle -> grants 0,1,2,3,0 on consecutive cycles.
REQ-034 SHALL verify: host_req together with core_req=4'b0110 -> host_gnt=1, then core 1 is granted the next cycle once the host drops, and rr_ptr is unchanged by the host grant.
REQ-035 SHALL verify: core 2 reads addr 0x010 holding 0xBEEF -> core_rvalid[2]=1 one cycle later with core_rdata=0xBEEF, and no other rvalid bit is set.
REQ-036 SHALL verify: core 1 with core_lock=1 for 3 cycles while the host requests -> core 1 is granted 3 times with arb_state=LOCK, then host_gnt=1.
REQ-037 SHALL verify: rst_n pulsed low during a granted read -> no rvalid after release, arb_state=IDLE, and the next core-0 request is granted first.
REQ-038 SHALL verify, with ARB_CONFLICT_CNT_EN: 5 cycles with 2 cores requesting -> conflict_cnt=5.
